gsu_ram_arbiter: RTL and testbench

GSU_RAM_ARBITER -- requirements
Module: gsu_ram_arbiter

---
 rtl/gsu_ram_arbiter_pkg.sv | 21 ++
 rtl/gsu_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_gsu_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsu_ram_arbiter_pkg.sv
// Shared types for the GSU / SNES backup-RAM arbiter.
package gsu_ram_arbiter_pkg;

  // Memory-side address width and wait-counter width.
  localparam int unsigned BSRAM_AW = 20;
  localparam int unsigned WAIT_W   = 4;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Requester identity; also used to remember the previous grant.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_GSU = 1'b1
  } req_id_t;

endpackage

// File: rtl/gsu_ram_arbiter.sv
// Two-requester (SNES CPU / GSU core) arbiter for a single backup-RAM port.
// One access at a time: IDLE grants, ACCESS drives the strobes for
// WAIT_CYCLES cycles, DONE pulses the winner's ACK for one cycle.
module gsu_ram_arbiter
  import gsu_ram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              MCLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic              CPU_ACK,
  output logic [7:0]        CPU_RDATA,
  input  logic              GSU_REQ,
  input  logic              GSU_WE,
  input  logic [ADDR_W-1:0] GSU_ADDR,
  input  logic [7:0]        GSU_WDATA,
  output logic              GSU_ACK,
  output logic [7:0]        GSU_RDATA,
  input  logic              RAN,
  input  logic [19:0]       BSRAM_MASK,
  output logic [19:0]       BSRAM_ADDR,
  output logic [7:0]        BSRAM_D,
  input  logic [7:0]        BSRAM_Q,
  output logic              BSRAM_CE_N,
  output logic              BSRAM_OE_N,
  output logic              BSRAM_WE_N,
  output logic              BUSY
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  arb_state_t            state_q;
  arb_state_t            state_d;
  req_id_t               owner_q;     // current grant, and last grant once idle
  req_id_t               winner;
  logic                  we_q;
  logic [BSRAM_AW-1:0]   addr_q;
  logic [7:0]            wdata_q;
  logic [WAIT_W-1:0]     cnt_q;
  logic [7:0]            cpu_rdata_q;
  logic [7:0]            gsu_rdata_q;

  logic                  cpu_elig;
  logic                  gsu_elig;
  logic                  grant;
  logic                  last_beat;
  logic                  win_we;
  logic [ADDR_W-1:0]     win_addr;
  logic [7:0]            win_wdata;

  // Eligibility and winner selection: CPU by default, GSU when the CPU had the last grant.
  always_comb begin
    cpu_elig  = CPU_REQ;
    gsu_elig  = GSU_REQ & RAN;
    grant     = cpu_elig | gsu_elig;
    winner    = REQ_CPU;
    if (cpu_elig && gsu_elig) begin
      winner = (owner_q == REQ_CPU) ? REQ_GSU : REQ_CPU;
    end else if (gsu_elig) begin
      winner = REQ_GSU;
    end
    win_we    = (winner == REQ_GSU) ? GSU_WE    : CPU_WE;
    win_addr  = (winner == REQ_GSU) ? GSU_ADDR  : CPU_ADDR;
    win_wdata = (winner == REQ_GSU) ? GSU_WDATA : CPU_WDATA;
  end

  // Next-state, memory strobe and acknowledge decode.
  always_comb begin
    state_d    = state_q;
    last_beat  = 1'b0;
    BSRAM_CE_N = 1'b1;
    BSRAM_OE_N = 1'b1;
    BSRAM_WE_N = 1'b1;
    CPU_ACK    = 1'b0;
    GSU_ACK    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        BSRAM_CE_N = 1'b0;
        BSRAM_OE_N = we_q;
        BSRAM_WE_N = ~we_q;
        if (cnt_q == '0) begin
          last_beat = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        CPU_ACK = (owner_q == REQ_CPU);
        GSU_ACK = (owner_q == REQ_GSU);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant capture, wait countdown and read-data capture into the granted side.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      owner_q     <= REQ_GSU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      gsu_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant) begin
        owner_q <= winner;
        we_q    <= win_we;
        // Mask applied at grant so a mask change mid-access cannot move the address.
        addr_q  <= BSRAM_AW'(win_addr) & BSRAM_MASK;
        wdata_q <= win_wdata;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ACCESS) begin
        if (!last_beat) begin
          cnt_q <= cnt_q - 1'b1;
        end else if (!we_q) begin
          if (owner_q == REQ_GSU) begin
            gsu_rdata_q <= BSRAM_Q;
          end else begin
            cpu_rdata_q <= BSRAM_Q;
          end
        end
      end
    end
  end

  assign BSRAM_ADDR = addr_q;
  assign BSRAM_D    = wdata_q;
  assign CPU_RDATA  = cpu_rdata_q;
  assign GSU_RDATA  = gsu_rdata_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_gsu_ram_arbiter.sv
// Self-checking bench for gsu_ram_arbiter: transaction-level reference model
// (cycle age since grant) compared every cycle, plus directed literal checks.
module tb_gsu_ram_arbiter;

  localparam int unsigned W  = 3;
  localparam int unsigned AW = 17;

  logic          MCLK = 1'b0;
  logic          RST;
  logic          CPU_REQ, CPU_WE, CPU_ACK;
  logic [AW-1:0] CPU_ADDR;
  logic [7:0]    CPU_WDATA, CPU_RDATA;
  logic          GSU_REQ, GSU_WE, GSU_ACK;
  logic [AW-1:0] GSU_ADDR;
  logic [7:0]    GSU_WDATA, GSU_RDATA;
  logic          RAN;
  logic [19:0]   BSRAM_MASK, BSRAM_ADDR;
  logic [7:0]    BSRAM_D, BSRAM_Q;
  logic          BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N, BUSY;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] salt = 8'h00;
  logic       q_fixed = 1'b0;
  logic [7:0] q_val = 8'h00;
  logic       chk_en = 1'b0;

  always #5 MCLK = ~MCLK;

  gsu_ram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .MCLK(MCLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .GSU_REQ(GSU_REQ), .GSU_WE(GSU_WE), .GSU_ADDR(GSU_ADDR), .GSU_WDATA(GSU_WDATA),
    .GSU_ACK(GSU_ACK), .GSU_RDATA(GSU_RDATA),
    .RAN(RAN), .BSRAM_MASK(BSRAM_MASK), .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D),
    .BSRAM_Q(BSRAM_Q), .BSRAM_CE_N(BSRAM_CE_N), .BSRAM_OE_N(BSRAM_OE_N),
    .BSRAM_WE_N(BSRAM_WE_N), .BUSY(BUSY)
  );

  // Memory read data depends on address and a salt that changes every cycle,
  // so capturing on the wrong cycle or address shows up.
  function automatic logic [7:0] ram_q(input logic [19:0] a, input logic [7:0] s,
                                       input logic fx, input logic [7:0] fv);
    if (fx) return fv;
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ s ^ 8'h3C;
  endfunction

  assign BSRAM_Q = ram_q(BSRAM_ADDR, salt, q_fixed, q_val);

  always @(negedge MCLK) salt <= salt + 8'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_active = 1'b0;
  int unsigned m_age = 0;       // 1..W = access cycles, W+1 = ack cycle
  bit          m_gsu = 1'b0;
  bit          m_we = 1'b0;
  bit          m_last_gsu = 1'b1;
  logic [19:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_cpu_rd = '0;
  logic [7:0]  m_gsu_rd = '0;

  initial forever begin
    @(posedge MCLK);
    if (RST) begin
      m_active = 1'b0; m_age = 0; m_last_gsu = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_gsu_rd = '0;
    end else if (m_active) begin
      if (m_age == W && !m_we) begin
        if (m_gsu) m_gsu_rd = ram_q(m_addr, salt, q_fixed, q_val);
        else       m_cpu_rd = ram_q(m_addr, salt, q_fixed, q_val);
      end
      if (m_age == W + 1) m_active = 1'b0;
      else                m_age = m_age + 1;
    end else begin
      bit ce, ge, pick;
      ce = CPU_REQ;
      ge = GSU_REQ && RAN;
      if (ce || ge) begin
        pick = ge && (!ce || !m_last_gsu);
        m_gsu = pick; m_last_gsu = pick; m_active = 1'b1; m_age = 1;
        m_we    = pick ? GSU_WE : CPU_WE;
        m_addr  = 20'(pick ? GSU_ADDR : CPU_ADDR) & BSRAM_MASK;
        m_wdata = pick ? GSU_WDATA : CPU_WDATA;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_acc, e_done;
  initial forever begin
    @(negedge MCLK);
    if (chk_en) begin
      e_acc  = m_active && (m_age <= W);
      e_done = m_active && (m_age == W + 1);
      check("busy",      32'(BUSY),       32'(m_active));
      check("ce_n",      32'(BSRAM_CE_N), 32'(!e_acc));
      check("oe_n",      32'(BSRAM_OE_N), 32'(!(e_acc && !m_we)));
      check("we_n",      32'(BSRAM_WE_N), 32'(!(e_acc && m_we)));
      check("addr",      32'(BSRAM_ADDR), 32'(m_addr));
      if (e_acc && m_we) check("wdata", 32'(BSRAM_D), 32'(m_wdata));
      check("cpu_ack",   32'(CPU_ACK),    32'(e_done && !m_gsu));
      check("gsu_ack",   32'(GSU_ACK),    32'(e_done && m_gsu));
      check("cpu_rdata", 32'(CPU_RDATA),  32'(m_cpu_rd));
      check("gsu_rdata", 32'(GSU_RDATA),  32'(m_gsu_rd));
      check("ack_excl",  32'(CPU_ACK & GSU_ACK), 32'(0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_ack(input bit gsu, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge MCLK);
      if (gsu ? GSU_ACK : CPU_ACK) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One isolated access from an idle arbiter; called just after a rising edge.
  task automatic single_access(input bit gsu, input bit we, input logic [AW-1:0] a,
                               input logic [7:0] d, output int lat, output int sc,
                               output logic [19:0] a_seen, output logic [7:0] rd);
    if (gsu) begin GSU_REQ = 1'b1; GSU_WE = we; GSU_ADDR = a; GSU_WDATA = d; end
    else     begin CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d; end
    lat = 0; sc = 0; a_seen = '0; rd = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      @(negedge MCLK);
      if (!BSRAM_OE_N || !BSRAM_WE_N) begin sc++; a_seen = BSRAM_ADDR; end
      if (gsu ? GSU_ACK : CPU_ACK) begin
        rd = gsu ? GSU_RDATA : CPU_RDATA;
        break;
      end
    end
    CPU_REQ = 1'b0;
    GSU_REQ = 1'b0;
    tick();
  endtask

  int          lat, sc, nacks, coinc, busy_hits;
  logic [19:0] a_seen;
  logic [7:0]  rd;
  bit          got, prev_we_n, ca, ga;
  int          order[$];
  logic [7:0]  win_d[$];
  logic [19:0] win_a[$];
  logic [19:0] masks[4] = '{20'h1FFFF, 20'h07FFF, 20'hFFFFF, 20'h0F0F0};

  initial begin
    RST = 1'b1; RAN = 1'b0; BSRAM_MASK = 20'h1FFFF;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    GSU_REQ = 1'b0; GSU_WE = 1'b0; GSU_ADDR = '0; GSU_WDATA = '0;
    repeat (2) @(posedge MCLK);
    #1;
    chk_en = 1'b1;
    RST = 1'b0;

    // Reset state literals.
    @(negedge MCLK);
    check("rst_ce_n",  32'(BSRAM_CE_N), 32'(1));
    check("rst_oe_n",  32'(BSRAM_OE_N), 32'(1));
    check("rst_we_n",  32'(BSRAM_WE_N), 32'(1));
    check("rst_addr",  32'(BSRAM_ADDR), 32'h0);
    check("rst_d",     32'(BSRAM_D),    32'h0);
    check("rst_busy",  32'(BUSY),       32'(0));
    check("rst_acks",  32'({CPU_ACK, GSU_ACK}), 32'(0));
    check("rst_rdata", 32'({CPU_RDATA, GSU_RDATA}), 32'h0);
    tick();

    // Single CPU read with fixed memory data.
    q_fixed = 1'b1; q_val = 8'h5A;
    single_access(1'b0, 1'b0, 17'h01234, 8'h00, lat, sc, a_seen, rd);
    check("cpu_rd_latency", 32'(lat),    32'd4);
    check("cpu_rd_oe_cyc",  32'(sc),     32'd3);
    check("cpu_rd_addr",    32'(a_seen), 32'h01234);
    check("cpu_rd_data",    32'(rd),     32'h5A);
    @(negedge MCLK);
    check("cpu_rd_held",    32'(CPU_RDATA), 32'h5A);
    check("gsu_rd_untouched", 32'(GSU_RDATA), 32'h00);
    tick();

    // Mask narrows the address; GSU read and GSU write.
    RAN = 1'b1; BSRAM_MASK = 20'h07FFF; q_val = 8'hC3;
    single_access(1'b1, 1'b0, 17'h1FFFF, 8'h00, lat, sc, a_seen, rd);
    check("mask_addr",     32'(a_seen), 32'h07FFF);
    check("mask_rd_data",  32'(rd),     32'hC3);
    check("gsu_latency",   32'(lat),    32'd4);
    single_access(1'b1, 1'b1, 17'h00ABC, 8'h96, lat, sc, a_seen, rd);
    check("gsu_wr_we_cyc", 32'(sc),     32'd3);
    check("gsu_wr_addr",   32'(a_seen), 32'h00ABC);
    check("gsu_rd_held",   32'(GSU_RDATA), 32'hC3);
    BSRAM_MASK = 20'h1FFFF;

    // Simultaneous writes after reset: CPU first, one WE window each.
    pulse_reset();
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 17'h00100; CPU_WDATA = 8'hA5;
    GSU_REQ = 1'b1; GSU_WE = 1'b1; GSU_ADDR = 17'h00200; GSU_WDATA = 8'h3C;
    prev_we_n = 1'b1;
    order.delete(); win_d.delete(); win_a.delete();
    for (int i = 0; i < 40 && (CPU_REQ || GSU_REQ); i++) begin
      @(negedge MCLK);
      if (!BSRAM_WE_N && prev_we_n) begin win_d.push_back(BSRAM_D); win_a.push_back(BSRAM_ADDR); end
      prev_we_n = BSRAM_WE_N;
      if (CPU_ACK) begin order.push_back(0); CPU_REQ = 1'b0; end
      if (GSU_ACK) begin order.push_back(1); GSU_REQ = 1'b0; end
    end
    check("dual_acks",    32'(order.size()), 32'd2);
    check("dual_windows", 32'(win_d.size()), 32'd2);
    if (order.size() >= 2) begin
      check("dual_first_cpu",  32'(order[0]), 32'd0);
      check("dual_second_gsu", 32'(order[1]), 32'd1);
    end
    if (win_d.size() >= 2) begin
      check("dual_w0_data", 32'(win_d[0]), 32'hA5);
      check("dual_w0_addr", 32'(win_a[0]), 32'h00100);
      check("dual_w1_data", 32'(win_d[1]), 32'h3C);
      check("dual_w1_addr", 32'(win_a[1]), 32'h00200);
    end
    tick();

    // GSU blocked while RAN=0, granted the cycle after RAN rises.
    RAN = 1'b0;
    GSU_REQ = 1'b1; GSU_WE = 1'b0; GSU_ADDR = 17'h00777;
    busy_hits = 0;
    repeat (20) begin
      @(negedge MCLK);
      if (BUSY) busy_hits++;
    end
    check("ran0_no_grant", 32'(busy_hits), 32'd0);
    RAN = 1'b1;
    @(negedge MCLK);
    check("ran1_busy", 32'(BUSY),       32'(1));
    check("ran1_oe_n", 32'(BSRAM_OE_N), 32'(0));
    wait_ack(1'b1, got);
    check("ran1_ack", 32'(got), 32'(1));
    GSU_REQ = 1'b0;
    tick();

    // Continuous contention alternates CPU, GSU, CPU...
    pulse_reset();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h00011;
    GSU_REQ = 1'b1; GSU_WE = 1'b0; GSU_ADDR = 17'h00022;
    nacks = 0; coinc = 0; order.delete();
    for (int i = 0; i < 200 && nacks < 10; i++) begin
      @(negedge MCLK);
      if (CPU_ACK && GSU_ACK) coinc++;
      if (CPU_ACK) begin order.push_back(0); nacks++; end
      if (GSU_ACK) begin order.push_back(1); nacks++; end
    end
    CPU_REQ = 1'b0; GSU_REQ = 1'b0;
    check("alt_count", 32'(nacks), 32'd10);
    check("alt_coinc", 32'(coinc), 32'd0);
    foreach (order[i]) check("alt_order", 32'(order[i]), 32'(i % 2));
    tick();

    // Reset in the second access cycle aborts; held request is re-granted.
    pulse_reset();
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h00042;
    tick();
    tick();
    RST = 1'b1;
    @(negedge MCLK);
    check("abort_pre_ce_n", 32'(BSRAM_CE_N), 32'(0));
    tick();
    RST = 1'b0;
    @(negedge MCLK);
    check("abort_ce_n", 32'(BSRAM_CE_N), 32'(1));
    check("abort_oe_n", 32'(BSRAM_OE_N), 32'(1));
    check("abort_busy", 32'(BUSY),       32'(0));
    check("abort_ack",  32'(CPU_ACK),    32'(0));
    wait_ack(1'b0, got);
    check("abort_regrant", 32'(got), 32'(1));
    CPU_REQ = 1'b0;
    tick();

    // Randomized traffic against the model.
    q_fixed = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge MCLK);
      ca = CPU_ACK;
      ga = GSU_ACK;
      @(posedge MCLK);
      #1;
      RST = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) RAN = ~RAN;
      if ($urandom_range(0, 199) == 0) BSRAM_MASK = masks[$urandom_range(0, 3)];
      if (!CPU_REQ || ca) begin
        if ($urandom_range(0, 2) == 0) begin
          CPU_REQ = 1'b1; CPU_WE = 1'($urandom);
          CPU_ADDR = AW'($urandom); CPU_WDATA = 8'($urandom);
        end else begin
          CPU_REQ = 1'b0;
        end
      end
      if (!GSU_REQ || ga) begin
        if ($urandom_range(0, 2) == 0) begin
          GSU_REQ = 1'b1; GSU_WE = 1'($urandom);
          GSU_ADDR = AW'($urandom); GSU_WDATA = 8'($urandom);
        end else begin
          GSU_REQ = 1'b0;
        end
      end
    end
    CPU_REQ = 1'b0; GSU_REQ = 1'b0; RST = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
